// File: rtl/hdb3_enc.sv
// HDB3 line encoder: NRZ bits in, bipolar BP/BN rails out, four-strobe latency.
// A four-deep symbol delay line lets a B00V substitution reach back to the first zero of the run.
module hdb3_enc #(
  parameter bit INIT_POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic din_vld,
  output logic BP,
  output logic BN,
  output logic dout_vld
);

  typedef enum logic [1:0] {
    SYM_ZERO = 2'd0,
    SYM_ONE  = 2'd1,
    SYM_V    = 2'd2,
    SYM_B    = 2'd3
  } sym_t;

  sym_t       r_s3, r_s2, r_s1, r_s0;
  logic [1:0] r_zcnt;
  logic       r_odd;
  logic       r_last_pol;

  logic w_sub;
  sym_t w_new;
  sym_t w_s3_next;
  logic w_mark;
  logic w_pol;
  logic w_bp;
  logic w_bn;

  always_comb begin
    w_sub = 1'b0;
    w_new = SYM_ZERO;
    if (din) begin
      w_new = SYM_ONE;
    end else if (r_zcnt == 2'd3) begin
      w_sub = 1'b1;
      w_new = SYM_V;
    end
    // B00V: the run's first zero is in s2, on its way into s3
    w_s3_next = (w_sub && !r_odd) ? SYM_B : r_s2;
  end

  // Polarity 0 drives BP, 1 drives BN; a violation repeats the last mark's polarity
  always_comb begin
    w_mark = (r_s3 == SYM_ONE) || (r_s3 == SYM_B);
    w_pol  = w_mark ? ~r_last_pol : r_last_pol;
    w_bp   = (r_s3 != SYM_ZERO) && !w_pol;
    w_bn   = (r_s3 != SYM_ZERO) && w_pol;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s3       <= SYM_ZERO;
      r_s2       <= SYM_ZERO;
      r_s1       <= SYM_ZERO;
      r_s0       <= SYM_ZERO;
      r_zcnt     <= 2'd0;
      r_odd      <= 1'b0;
      r_last_pol <= ~INIT_POL;
      BP         <= 1'b0;
      BN         <= 1'b0;
      dout_vld   <= 1'b0;
    end else begin
      dout_vld <= din_vld;
      if (din_vld) begin
        BP   <= w_bp;
        BN   <= w_bn;
        r_s3 <= w_s3_next;
        r_s2 <= r_s1;
        r_s1 <= r_s0;
        r_s0 <= w_new;
        if (w_mark) begin
          r_last_pol <= ~r_last_pol;
        end
        if (din || w_sub) begin
          r_zcnt <= 2'd0;
        end else begin
          r_zcnt <= r_zcnt + 2'd1;
        end
        if (w_sub) begin
          r_odd <= 1'b0;
        end else if (din) begin
          r_odd <= ~r_odd;
        end
      end
    end
  end

endmodule

// File: tb/tb_hdb3_enc.sv
// Testbench for hdb3_enc: directed line-pattern cases plus randomized strobes and gaps
// compared against an array-based HDB3 reference model.
module tb_hdb3_enc;

  localparam bit INIT_POL = 1'b0;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic din_vld;
  logic BP;
  logic BN;
  logic dout_vld;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: symbol history per input bit, 0=zero 1=one 2=V 3=B
  int msym[$];
  int m_zrun;
  int m_ones;
  int m_last;
  int m_n;
  bit m_is_v;
  int lastv;
  bit have_v;
  int obs[$];

  int e27[$] = '{0,0,0,0, 1,-1,1,-1,1};
  int e28[$] = '{0,0,0,0, 1,0,0,1, -1,1,-1,1};
  int e29[$] = '{0,0,0,0, 1,0,0,0,1,-1};
  int e30[$] = '{0,0,0,0, 1,0,0,1, -1,0,0,-1, 1,-1,1,-1};

  hdb3_enc #(.INIT_POL(INIT_POL)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
    .BP(BP), .BN(BN), .dout_vld(dout_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int line_val();
    if (BP === 1'b1 && BN === 1'b1) return 9;
    if (BP === 1'b1) return 1;
    if (BN === 1'b1) return -1;
    if (BP === 1'b0 && BN === 1'b0) return 0;
    return 7;
  endfunction

  task automatic model_reset();
    msym.delete();
    obs.delete();
    m_zrun = 0;
    m_ones = 0;
    m_last = INIT_POL ? 0 : 1;
    m_n    = 0;
    have_v = 1'b0;
  endtask

  // Returns expected line value (+1/-1/0) for the strobe that carries bit b in
  function automatic int model_push(input bit b);
    int s;
    int p;
    if (b) begin
      msym.push_back(1);
      m_zrun = 0;
      m_ones++;
    end else if (m_zrun < 3) begin
      msym.push_back(0);
      m_zrun++;
    end else begin
      if (m_ones % 2 == 0) msym[msym.size()-3] = 3;
      msym.push_back(2);
      m_zrun = 0;
      m_ones = 0;
    end
    m_is_v = 1'b0;
    s = (m_n < 4) ? 0 : msym[m_n-4];
    m_n++;
    case (s)
      1, 3: begin
        p = 1 - m_last;
        m_last = p;
        return (p == 0) ? 1 : -1;
      end
      2: begin
        m_is_v = 1'b1;
        return (m_last == 0) ? 1 : -1;
      end
      default: return 0;
    endcase
  endfunction

  task automatic strobe(input bit b, input int gap);
    int exp_v;
    int v;
    din     = b;
    din_vld = 1'b1;
    @(negedge clk);
    exp_v = model_push(b);
    v = line_val();
    obs.push_back(v);
    chk("dout_vld_strobe", int'(dout_vld), 1);
    chk("line", v, exp_v);
    if (m_is_v) begin
      if (have_v) chk("v_alternate", v, -lastv);
      lastv  = v;
      have_v = 1'b1;
    end
    din_vld = 1'b0;
    din     = $urandom_range(0, 1);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("dout_vld_gap", int'(dout_vld), 0);
      chk("line_hold", line_val(), v);
    end
  endtask

  // Asserts rst mid-cycle, checks the asynchronous clear, then releases on a negedge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_line", line_val(), 0);
    chk("rst_async_vld", int'(dout_vld), 0);
    for (int i = 0; i < 4; i++) begin
      din_vld = i[0];
      din     = $urandom_range(0, 1);
      @(negedge clk);
      chk("rst_hold_line", line_val(), 0);
      chk("rst_hold_vld", int'(dout_vld), 0);
    end
    din_vld = 1'b0;
    rst     = 1'b0;
    model_reset();
  endtask

  task automatic chk_seq(input string tag, input int exp[$]);
    chk({tag, "_len"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
      chk(tag, obs[i], exp[i]);
    end
  endtask

  initial begin
    rst     = 1'b1;
    din     = 1'b0;
    din_vld = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset behaviour with strobes toggling
    do_reset();

    // All ones
    for (int i = 0; i < 9; i++) strobe(1'b1, 0);
    chk_seq("ones", e27);

    // B00V
    do_reset();
    for (int i = 0; i < 4; i++) strobe(1'b0, 0);
    for (int i = 0; i < 8; i++) strobe(1'b1, 0);
    chk_seq("b00v", e28);

    // 000V
    do_reset();
    strobe(1'b1, 0);
    for (int i = 0; i < 4; i++) strobe(1'b0, 0);
    for (int i = 0; i < 5; i++) strobe(1'b1, 0);
    chk_seq("000v", e29);

    // Eight zeros: two substitutions with alternating V
    do_reset();
    for (int i = 0; i < 8; i++) strobe(1'b0, 0);
    for (int i = 0; i < 8; i++) strobe(1'b1, 0);
    chk_seq("two_v", e30);

    // Strobe gaps
    do_reset();
    strobe(1'b1, 3);
    strobe(1'b0, 3);
    strobe(1'b1, 3);
    for (int i = 0; i < 4; i++) strobe(1'b1, 3);

    // Mid-run reset, then B00V stimulus must reproduce exactly
    for (int i = 0; i < 3; i++) strobe(1'b0, 1);
    do_reset();
    for (int i = 0; i < 4; i++) strobe(1'b0, 0);
    for (int i = 0; i < 8; i++) strobe(1'b1, 0);
    chk_seq("b00v_rerun", e28);

    // Randomized, zero-heavy data with random gaps and one mid-stream reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      strobe(($urandom_range(0, 2) == 0), $urandom_range(0, 2));
      if (i == 200) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Exclusive rails on every negedge
  always @(negedge clk) begin
    if (BP === 1'b1 && BN === 1'b1) begin
      n_err++;
      $error("FAIL rails_exclusive observed=BP1BN1 expected=not_both");
    end
  end

endmodule
